// File: rtl/proj_monitor_pkg.sv
// Shared state encoding and constants for the project result monitor.
// Verdict codes give benches a compact way to name the sticky outcome.
package proj_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_0001;
   localparam logic [31:0] DEFAULT_FAIL_CODE = 32'h0000_0BAD;

   localparam logic [1:0] VERDICT_NONE    = 2'd0;
   localparam logic [1:0] VERDICT_PASS    = 2'd1;
   localparam logic [1:0] VERDICT_FAIL    = 2'd2;
   localparam logic [1:0] VERDICT_TIMEOUT = 2'd3;

   function automatic logic [1:0] verdict_of(input state_e st);
      logic [1:0] v;
      case (st)
         ST_PASS:    v = VERDICT_PASS;
         ST_FAIL:    v = VERDICT_FAIL;
         ST_TIMEOUT: v = VERDICT_TIMEOUT;
         default:    v = VERDICT_NONE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/stable_match_counter.sv
// Counts consecutive match samples; hit fires combinationally on the sample that
// completes N in a row.
module stable_match_counter #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned N     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic match,
   output logic hit
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

   logic [WIDTH-1:0] stab_q;
   logic [WIDTH-1:0] stab_d;

   assign hit = en && match && (stab_q == LAST);

   // Holds at LAST once reached so the count never runs past N-1.
   always_comb begin
      stab_d = stab_q;
      if (clear) begin
         stab_d = '0;
      end else if (en) begin
         if (!match) begin
            stab_d = '0;
         end else if (stab_q != LAST) begin
            stab_d = stab_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stab_q <= '0;
      end else begin
         stab_q <= stab_d;
      end
   end

endmodule

// File: rtl/proj_result_monitor.sv
// Observer for the frame result buses: arms on start, then reports a sticky
// PASS / FAIL / TIMEOUT verdict along with RUN cycle and out2 activity counts.
module proj_result_monitor
   import proj_monitor_pkg::*;
#(
   parameter int unsigned         DATA_W         = 32,
   parameter logic [DATA_W-1:0]   PASS_CODE      = DATA_W'(DEFAULT_PASS_CODE),
   parameter logic [DATA_W-1:0]   FAIL_CODE      = DATA_W'(DEFAULT_FAIL_CODE),
   parameter int unsigned         STABLE_CYCLES  = 4,
   parameter int unsigned         TIMEOUT_CYCLES = 100000,
   parameter int unsigned         CNT_W          = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] out1,
   input  logic [DATA_W-1:0] out2,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [15:0]       out2_changes,
   output logic [DATA_W-1:0] final_out2
);

   localparam int unsigned      STAB_W       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   if (PASS_CODE == FAIL_CODE) begin : g_code_clash
      $error("proj_result_monitor: PASS_CODE and FAIL_CODE must differ");
   end
   if (STABLE_CYCLES < 1) begin : g_stable_range
      $error("proj_result_monitor: STABLE_CYCLES must be at least 1");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
      $error("proj_result_monitor: TIMEOUT_CYCLES must be at least 2");
   end

   state_e            state_q;
   state_e            state_d;
   state_e            verdict;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [15:0]       chg_q;
   logic [15:0]       chg_d;
   logic [DATA_W-1:0] prev_q;
   logic [DATA_W-1:0] prev_d;
   logic [DATA_W-1:0] final_q;
   logic [DATA_W-1:0] final_d;
   logic              stab_clear;
   logic              running;
   logic              pass_hit;

   assign running = (state_q == ST_RUN);

   stable_match_counter #(
      .WIDTH (STAB_W),
      .N     (STABLE_CYCLES)
   ) u_stable (
      .clk   (clk),
      .reset (reset),
      .clear (stab_clear),
      .en    (running),
      .match (out1 == PASS_CODE),
      .hit   (pass_hit)
   );

   // Verdict priority on the current sample: FAIL, then PASS, then TIMEOUT.
   always_comb begin
      verdict = ST_RUN;
      if (out1 == FAIL_CODE) begin
         verdict = ST_FAIL;
      end else if (pass_hit) begin
         verdict = ST_PASS;
      end else if (cnt_q == TIMEOUT_LAST) begin
         verdict = ST_TIMEOUT;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      chg_d      = chg_q;
      prev_d     = prev_q;
      final_d    = final_q;
      stab_clear = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               cnt_d      = '0;
               chg_d      = '0;
               prev_d     = out2;
               stab_clear = 1'b1;
            end
         end
         ST_RUN: begin
            // Counters take this sample's increment even on the verdict edge.
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if ((out2 != prev_q) && (chg_q != 16'hFFFF)) begin
               chg_d = chg_q + 16'd1;
            end
            prev_d = out2;
            if (verdict != ST_RUN) begin
               state_d = verdict;
               final_d = out2;
            end
         end
         ST_PASS, ST_FAIL, ST_TIMEOUT: begin
            state_d = state_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         chg_q   <= '0;
         prev_q  <= '0;
         final_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chg_q   <= chg_d;
         prev_q  <= prev_d;
         final_q <= final_d;
      end
   end

   assign busy         = running;
   assign pass         = (state_q == ST_PASS);
   assign fail         = (state_q == ST_FAIL);
   assign timeout      = (state_q == ST_TIMEOUT);
   assign done         = pass || fail || timeout;
   assign cycle_count  = cnt_q;
   assign out2_changes = chg_q;
   assign final_out2   = final_q;

endmodule

// File: tb/tb_proj_result_monitor.sv
// Bench for proj_result_monitor: two configurations share stimulus, each tracked by
// a behavioural model compared every cycle, plus directed scenarios with literal checks.
module tb_proj_result_monitor;
   import proj_monitor_pkg::*;

   localparam logic [31:0] PCODE = 32'h1;
   localparam logic [31:0] FCODE = 32'hBAD;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] out1;
   logic [31:0] out2;

   logic        busy_a, done_a, pass_a, fail_a, timeout_a;
   logic [31:0] cc_a;
   logic [15:0] chg_a;
   logic [31:0] fin_a;
   logic        busy_b, done_b, pass_b, fail_b, timeout_b;
   logic [31:0] cc_b;
   logic [15:0] chg_b;
   logic [31:0] fin_b;
   logic [4:0]  flags_a;
   logic [4:0]  flags_b;

   int checks;
   int failures;

   assign flags_a = {busy_a, done_a, pass_a, fail_a, timeout_a};
   assign flags_b = {busy_b, done_b, pass_b, fail_b, timeout_b};

   proj_result_monitor dut_a (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .out1         (out1),
      .out2         (out2),
      .busy         (busy_a),
      .done         (done_a),
      .pass         (pass_a),
      .fail         (fail_a),
      .timeout      (timeout_a),
      .cycle_count  (cc_a),
      .out2_changes (chg_a),
      .final_out2   (fin_a)
   );

   proj_result_monitor #(
      .STABLE_CYCLES  (1),
      .TIMEOUT_CYCLES (10)
   ) dut_b (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .out1         (out1),
      .out2         (out2),
      .busy         (busy_b),
      .done         (done_b),
      .pass         (pass_b),
      .fail         (fail_b),
      .timeout      (timeout_b),
      .cycle_count  (cc_b),
      .out2_changes (chg_b),
      .final_out2   (fin_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // phase: 0 idle, 1 run, 2 verdict reached. run = trailing PASS_CODE samples.
   typedef struct {
      int          phase;
      logic [1:0]  verdict;
      longint      cyc;
      int          chg;
      logic [31:0] prev;
      logic [31:0] fin;
      int          run;
   } m_t;

   m_t   ma;
   m_t   mb;
   logic mvalid = 1'b0;

   function automatic m_t model_reset();
      m_t m;
      m.phase = 0; m.verdict = VERDICT_NONE; m.cyc = 0; m.chg = 0;
      m.prev = '0; m.fin = '0; m.run = 0;
      return m;
   endfunction

   function automatic m_t model_step(m_t m, logic st, logic [31:0] o1, logic [31:0] o2,
                                     int stable, longint tmo);
      m_t n = m;
      if (m.phase == 0) begin
         if (st) begin
            n.phase = 1; n.cyc = 0; n.chg = 0; n.prev = o2; n.run = 0;
         end
      end else if (m.phase == 1) begin
         n.cyc  = (m.cyc >= 64'hFFFF_FFFF) ? m.cyc : m.cyc + 1;
         if (o2 != m.prev && m.chg < 65535) n.chg = m.chg + 1;
         n.prev = o2;
         n.run  = (o1 == PCODE) ? m.run + 1 : 0;
         if (o1 == FCODE)            n.verdict = VERDICT_FAIL;
         else if (n.run >= stable)   n.verdict = VERDICT_PASS;
         else if (m.cyc + 1 == tmo)  n.verdict = VERDICT_TIMEOUT;
         if (n.verdict != VERDICT_NONE) begin
            n.phase = 2;
            n.fin   = o2;
         end
      end
      return n;
   endfunction

   function automatic logic [4:0] model_flags(m_t m);
      return {m.phase == 1, m.phase == 2, m.verdict == VERDICT_PASS,
              m.verdict == VERDICT_FAIL, m.verdict == VERDICT_TIMEOUT};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         ma     <= model_reset();
         mb     <= model_reset();
         mvalid <= 1'b1;
      end else if (mvalid) begin
         ma <= model_step(ma, start, out1, out2, 4, 100000);
         mb <= model_step(mb, start, out1, out2, 1, 10);
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("a_flags", 64'(flags_a), 64'(model_flags(ma)));
         chk("a_cycle_count", 64'(cc_a), 64'(ma.cyc));
         chk("a_out2_changes", 64'(chg_a), 64'(ma.chg));
         chk("a_final_out2", 64'(fin_a), 64'(ma.fin));
         chk("b_flags", 64'(flags_b), 64'(model_flags(mb)));
         chk("b_cycle_count", 64'(cc_b), 64'(mb.cyc));
         chk("b_out2_changes", 64'(chg_b), 64'(mb.chg));
         chk("b_final_out2", 64'(fin_b), 64'(mb.fin));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; out1 = '0; out2 = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic arm();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      checks = 0; failures = 0;
      reset = 1'b1; start = 1'b0; out1 = '0; out2 = '0;
      tick();

      // Reset state
      do_reset();
      chk("reset_flags", 64'(flags_a), 64'd0);
      chk("reset_cycle_count", 64'(cc_a), 64'd0);
      chk("reset_changes", 64'(chg_a), 64'd0);
      chk("reset_final", 64'(fin_a), 64'd0);

      // 1: pass after 4 consecutive matches starting at cycle 3
      arm();
      out1 = '0;
      repeat (2) tick();
      out1 = PCODE;
      repeat (3) tick();
      chk("t1_pass_early", 64'(pass_a), 64'd0);
      tick();
      chk("t1_flags", 64'(flags_a), 64'b01100);
      chk("t1_cycle_count", 64'(cc_a), 64'd6);
      chk("t1_b_pass_first_match", 64'(flags_b), 64'b01100);
      chk("t1_b_cycle_count", 64'(cc_b), 64'd3);

      // 2: a zero in the middle restarts the consecutive run
      do_reset();
      arm();
      pat = 8'b1111_0111;
      for (int i = 0; i < 8; i++) begin
         out1 = pat[i] ? PCODE : 32'h0;
         tick();
         if (i == 6) chk("t2_pass_early", 64'(pass_a), 64'd0);
      end
      chk("t2_pass", 64'(pass_a), 64'd1);
      chk("t2_cycle_count", 64'(cc_a), 64'd8);

      // 3: single FAIL_CODE sample, later PASS_CODE ignored
      do_reset();
      arm();
      out1 = '0;
      repeat (3) begin
         out2 = $urandom;
         tick();
      end
      out1 = FCODE; out2 = 32'hCAFE_0003;
      tick();
      chk("t3_fail", 64'(flags_a), 64'b01010);
      chk("t3_final_out2", 64'(fin_a), 64'hCAFE_0003);
      out1 = PCODE;
      repeat (5) tick();
      chk("t3_sticky", 64'(flags_a), 64'b01010);

      // 4: timeout after 10 RUN cycles, start re-pulse ignored
      do_reset();
      out2 = '0;
      arm();
      out1 = '0;
      repeat (9) tick();
      chk("t4_no_timeout_yet", 64'(timeout_b), 64'd0);
      tick();
      chk("t4_timeout", 64'(flags_b), 64'b01001);
      chk("t4_cycle_count", 64'(cc_b), 64'd10);
      arm();
      tick();
      chk("t4_restart_ignored", 64'(flags_b), 64'b01001);
      chk("t4_count_frozen", 64'(cc_b), 64'd10);

      // 5: six toggles then hold; then enough toggles to saturate
      do_reset();
      out2 = '0;
      arm();
      for (int i = 0; i < 6; i++) begin
         out2 = ~out2;
         tick();
      end
      repeat (3) tick();
      chk("t5_changes", 64'(chg_a), 64'd6);
      for (int i = 0; i < 66000; i++) begin
         out2 = ~out2;
         tick();
      end
      chk("t5_saturate", 64'(chg_a), 64'hFFFF);
      chk("t5_cycle_count", 64'(cc_a), 64'd66009);

      // 6: reset mid-run with 3 matches pending, then a fresh run
      do_reset();
      arm();
      out1 = PCODE;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_flags", 64'(flags_a), 64'd0);
      chk("t6_cycle_count", 64'(cc_a), 64'd0);
      arm();
      out1 = '0;
      repeat (2) tick();
      chk("t6_fresh_busy", 64'(flags_a), 64'b10000);
      chk("t6_fresh_count", 64'(cc_a), 64'd2);

      // Randomized traffic against the models
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int r;
         reset = ((ma.phase == 2) && ($urandom_range(0, 9) == 0)) || ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 99);
         if (r < 70)      out1 = PCODE;
         else if (r < 73) out1 = FCODE;
         else if (r < 90) out1 = '0;
         else             out1 = $urandom;
         out2 = 32'($urandom_range(0, 3));
         tick();
      end
      reset = 1'b0; start = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
